// File: rtl/core_pkg.sv
// core_pkg: types shared by the fetch unit.
// Holds the redirect FSM states and the fetch FIFO entry layout.
package core_pkg;

  typedef enum logic {
    RUN,
    DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/core_fetch_fifo.sv
// core_fetch_fifo: synchronous FIFO of fetched instructions.
// Flush empties it in one cycle; push and pop may share a cycle when full.
module core_fetch_fifo
  import core_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic          not_empty,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_q;
  logic [AW-1:0] wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop    = pop & (cnt_q != '0);
  assign do_push   = push & ((cnt_q != CW'(DEPTH)) | do_pop);
  assign head      = mem_q[rd_q];
  assign not_empty = (cnt_q != '0);
  assign count     = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= nxt(wr_q);
      end
      if (do_pop) begin
        rd_q <= nxt(rd_q);
      end
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/core_fetch_redirect.sv
// core_fetch_redirect: fetch PC, imem request flow and flush handling.
// Define LETC_FETCH_PERF_EN to add saturating flush/drop counters.
module core_fetch_redirect
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        invalidate_fetch,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
`ifdef LETC_FETCH_PERF_EN
  ,
  output logic [31:0] perf_flush_count,
  output logic [31:0] perf_drop_count
`endif
);

  localparam int         CW    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [3:0] MAX_Q = 4'(MAX_OUTSTANDING);

  fetch_state_e  state_q;
  fetch_state_e  state_d;
  logic [31:0]   pc_q;
  logic [31:0]   rsp_pc_q;
  logic [2:0]    outst_q;
  logic [2:0]    outst_d;
  logic [2:0]    stale_q;
  logic [2:0]    stale_d;
  logic          live_q;
  logic [CW-1:0] fifo_cnt;
  logic          req_fire;
  logic          rsp_drop;
  logic          rsp_keep;
  logic          pop;
  fetch_entry_t  head;
  fetch_entry_t  push_data;

  // Budget covers both in-flight requests and buffered results.
  assign imem_req_valid = live_q & ~invalidate_fetch
                        & ((4'(outst_q) + 4'(fifo_cnt)) < MAX_Q);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign rsp_drop  = imem_rsp_valid
                   & (invalidate_fetch | (state_q == DRAIN));
  assign rsp_keep  = imem_rsp_valid & ~rsp_drop;
  assign pop       = out_valid & out_ready;
  assign push_data = '{pc: rsp_pc_q, instr: imem_rsp_data};
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

  always_comb begin
    outst_d = outst_q + 3'(req_fire) - 3'(imem_rsp_valid);
    stale_d = stale_q;
    if (invalidate_fetch) begin
      stale_d = outst_q - 3'(imem_rsp_valid);
    end else if (rsp_drop) begin
      stale_d = stale_q - 3'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (invalidate_fetch && stale_d != '0) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (stale_d == '0) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // rsp_pc_q tracks the PC owed to the next live response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      outst_q  <= '0;
      stale_q  <= '0;
      live_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      outst_q <= outst_d;
      stale_q <= stale_d;
      live_q  <= 1'b1;
      if (invalidate_fetch) begin
        pc_q     <= redirect_pc;
        rsp_pc_q <= redirect_pc;
      end else begin
        if (req_fire) begin
          pc_q <= pc_q + 32'd4;
        end
        if (rsp_keep) begin
          rsp_pc_q <= rsp_pc_q + 32'd4;
        end
      end
    end
  end

  core_fetch_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (invalidate_fetch),
    .push     (rsp_keep),
    .push_data(push_data),
    .pop      (pop),
    .head     (head),
    .not_empty(out_valid),
    .count    (fifo_cnt)
  );

`ifdef LETC_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_flush_count <= '0;
      perf_drop_count  <= '0;
    end else begin
      if (invalidate_fetch && perf_flush_count != '1) begin
        perf_flush_count <= perf_flush_count + 32'd1;
      end
      if (rsp_drop && perf_drop_count != '1) begin
        perf_drop_count <= perf_drop_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_core_fetch_redirect.sv
// tb_core_fetch_redirect: queue-based fetch model with directed redirects.
// Build with LETC_FETCH_PERF_EN to also check the perf counters.
module tb_core_fetch_redirect;

  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam int          MAXO   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        invalidate_fetch;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
`ifdef LETC_FETCH_PERF_EN
  logic [31:0] perf_flush_count;
  logic [31:0] perf_drop_count;
`endif

  typedef struct {
    logic [31:0] pc;
    int          rdy;
    bit          stale;
  } infl_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  infl_t       m_inf[$];
  ent_t        m_fifo[$];
  ent_t        obs[$];
  logic [31:0] m_pc = RST_PC;
  bit          m_live = 1'b0;
  int          m_drop = 0;
  int          m_flush = 0;
  int          lat = 1;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  core_fetch_redirect #(
    .RESET_PC       (RST_PC),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .invalidate_fetch(invalidate_fetch),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instr       (out_instr)
`ifdef LETC_FETCH_PERF_EN
    ,
    .perf_flush_count(perf_flush_count),
    .perf_drop_count (perf_drop_count)
`endif
  );

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_seq(input string nm,
                           input logic [31:0] base);
    chk({nm, "_len"}, 32'(obs.size() >= 3), 32'd1);
    if (obs.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        chk({nm, "_pc"}, obs[i].pc, base + 32'(4 * i));
        chk({nm, "_instr"}, obs[i].instr, f(base + 32'(4 * i)));
      end
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // imem: in-order, answers the oldest request once its latency elapses
  always @(posedge clk) begin
    #1;
    if (rst_n && m_inf.size() > 0 && m_inf[0].rdy <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = f(m_inf[0].pc);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  always @(negedge clk) begin
    bit   exp_rv;
    bit   exp_ov;
    bit   fire;
    bit   pop;
    bit   keep;
    infl_t e;
    if (!rst_n) begin
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
      m_inf.delete();
      m_fifo.delete();
      m_pc    = RST_PC;
      m_live  = 1'b0;
      m_drop  = 0;
      m_flush = 0;
`ifdef LETC_FETCH_PERF_EN
      chk("rst_perf_flush", perf_flush_count, 32'd0);
      chk("rst_perf_drop", perf_drop_count, 32'd0);
`endif
    end else begin
      exp_rv = m_live && !invalidate_fetch
             && (m_inf.size() + m_fifo.size() < MAXO);
      exp_ov = (m_fifo.size() != 0);
      chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      if (exp_ov) begin
        chk("out_pc", out_pc, m_fifo[0].pc);
        chk("out_instr", out_instr, m_fifo[0].instr);
      end
`ifdef LETC_FETCH_PERF_EN
      chk("perf_flush", perf_flush_count, 32'(m_flush));
      chk("perf_drop", perf_drop_count, 32'(m_drop));
`endif
      if (out_valid && out_ready) begin
        obs.push_back('{pc: out_pc, instr: out_instr});
      end
      fire = exp_rv && imem_req_ready;
      pop  = exp_ov && out_ready;
      keep = 1'b0;
      if (imem_rsp_valid && m_inf.size() > 0) begin
        e = m_inf.pop_front();
        if (invalidate_fetch || e.stale) m_drop++;
        else keep = 1'b1;
      end
      if (invalidate_fetch) begin
        m_flush++;
        foreach (m_inf[i]) m_inf[i].stale = 1'b1;
        m_fifo.delete();
        m_pc = redirect_pc;
      end else begin
        if (pop) void'(m_fifo.pop_front());
        if (keep) m_fifo.push_back('{pc: e.pc, instr: f(e.pc)});
        if (fire) begin
          m_inf.push_back('{pc: m_pc, rdy: cyc + lat, stale: 1'b0});
          m_pc = m_pc + 32'd4;
        end
      end
      m_live = 1'b1;
    end
  end

  task automatic redirect(input logic [31:0] a);
    invalidate_fetch = 1'b1;
    redirect_pc      = a;
    tick();
    invalidate_fetch = 1'b0;
  endtask

  initial begin
    int d0;
    int i;
    rst_n            = 1'b0;
    invalidate_fetch = 1'b0;
    redirect_pc      = '0;
    imem_req_ready   = 1'b1;
    out_ready        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    obs.delete();

    // sequential stream from reset
    repeat (15) tick();
    check_seq("seq_reset", 32'h0000_1000);
    if (obs.size() > 0) chk("seq_instr0", obs[0].instr, 32'hDEAD_AEEF);

    // flush with two requests in flight, none returning
    lat = 3;
    for (i = 0; i < 40; i++) begin
      if (m_inf.size() == 2 && m_inf[0].rdy > cyc) break;
      tick();
    end
    chk("wait_two_inflight", 32'(m_inf.size()), 32'd2);
    d0 = m_drop;
    redirect(32'h0000_2000);
    obs.delete();
    repeat (20) tick();
    check_seq("redirect", 32'h0000_2000);
    if (obs.size() > 0) chk("redir_instr0", obs[0].instr, 32'hDEAD_9EEF);
    chk("redirect_drops", 32'(m_drop - d0), 32'd2);

    // flush in the same cycle a response lands
    lat = 2;
    for (i = 0; i < 40; i++) begin
      if (m_inf.size() == 2 && m_inf[0].rdy <= cyc) break;
      tick();
    end
    chk("wait_rsp_inflight", 32'(m_inf.size()), 32'd2);
    d0 = m_drop;
    redirect(32'h0000_5000);
    obs.delete();
    repeat (20) tick();
    check_seq("same_cycle", 32'h0000_5000);
    chk("same_cycle_drops", 32'(m_drop - d0), 32'd2);

    // decode stall fills the buffer and stops requests
    lat = 1;
    out_ready = 1'b0;
    repeat (10) tick();
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    chk("stall_out_valid", 32'(out_valid), 32'd1);
    chk("stall_fill", 32'(m_fifo.size()), 32'(MAXO));
    obs.delete();
    out_ready = 1'b1;
    repeat (12) tick();
    chk("stall_len", 32'(obs.size() >= 4), 32'd1);
    if (obs.size() >= 4) begin
      for (int k = 1; k < 4; k++) begin
        chk("stall_order", obs[k].pc, obs[k-1].pc + 32'd4);
      end
    end

    // back-to-back flushes while draining
    lat = 3;
    for (i = 0; i < 40; i++) begin
      if (m_inf.size() == 2) break;
      tick();
    end
    invalidate_fetch = 1'b1;
    redirect_pc      = 32'h0000_3000;
    tick();
    redirect(32'h0000_4000);
    obs.delete();
    repeat (25) tick();
    check_seq("double", 32'h0000_4000);

    // random handshakes with occasional flushes
    for (int k = 0; k < 200; k++) begin
      lat            = int'($urandom_range(1, 3));
      imem_req_ready = 1'($urandom_range(0, 1));
      out_ready      = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        invalidate_fetch = 1'b1;
        redirect_pc      = 32'h0000_8000
                         + 32'($urandom_range(0, 63) << 2);
      end else begin
        invalidate_fetch = 1'b0;
      end
      tick();
    end
    invalidate_fetch = 1'b0;
    imem_req_ready   = 1'b1;
    out_ready        = 1'b1;

    // address wrap at the top of memory
    lat = 1;
    redirect(32'hFFFF_FFF8);
    obs.delete();
    repeat (15) tick();
    check_seq("wrap", 32'hFFFF_FFF8);
    if (obs.size() >= 3) chk("wrap_zero", obs[2].pc, 32'h0000_0000);

    // reset pulse mid-stream
    rst_n = 1'b0;
    #1;
    chk("async_req_valid", 32'(imem_req_valid), 32'd0);
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_out_pc", out_pc, 32'd0);
    chk("async_out_instr", out_instr, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    obs.delete();
    repeat (15) tick();
    check_seq("post_reset", 32'h0000_1000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
